// File: rtl/abr_masked_a2b_pkg.sv
// Shared types and constants for the masked A2B converter.
// Share-pair encoding: bit 1 = share1, bit 0 = share0.
package abr_masked_a2b_pkg;

    localparam int A2B_WIDTH = 8;

    typedef logic [1:0] share_t;
    typedef share_t [A2B_WIDTH-1:0] share_vec_t;

    // Field index of each randomness slice within rnd_i, in units of WIDTH.
    localparam int RND_R0  = 0;
    localparam int RND_R1  = 1;
    localparam int RND_ADD = 2;

endpackage

// File: rtl/abr_masked_share_fifo.sv
// DEPTH x WIDTH Boolean share-vector FIFO with occupancy count.
// Head is forced to zero while empty so no old entry is ever exposed.
module abr_masked_share_fifo
    import abr_masked_a2b_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0][1:0]       wr_data,
    input  logic                        rd_en,
    output logic [WIDTH-1:0][1:0]       rd_data,
    output logic                        valid,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = $clog2(DEPTH);

    share_t [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic               rd_ok;

    assign valid   = (count != '0);
    assign rd_ok   = rd_en & valid;
    assign rd_data = valid ? mem[rptr] : '0;

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Occupancy; simultaneous read and write leaves it unchanged.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else begin
            unique case ({wr_en, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/abr_masked_a2b_ctrl.sv
// Feeder and collector around the masked Boolean adder for A2B conversion.
// Credits cover in-flight plus buffered results, so nothing is ever dropped.
module abr_masked_a2b_ctrl
    import abr_masked_a2b_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int ADD_LAT = WIDTH + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    zeroize,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [WIDTH-1:0]        a0_i,
    input  logic [WIDTH-1:0]        a1_i,
    input  logic                    rnd_valid_i,
    input  logic [3*WIDTH-1:0]      rnd_i,
    output logic [WIDTH-1:0][1:0]   add_x_o,
    output logic [WIDTH-1:0][1:0]   add_y_o,
    output logic [WIDTH-1:0]        add_rnd_o,
    input  logic [WIDTH-1:0][1:0]   add_s_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH-1:0][1:0]   out_s_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic               clr;
    logic               acc;
    logic               wr_en;
    logic               rd_en;
    logic [ADD_LAT:0]   vld_q;
    logic [CW-1:0]      inflight_q;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        credit_used;
    logic [WIDTH-1:0]   r0;
    logic [WIDTH-1:0]   r1;
    logic [WIDTH-1:0]   radd;
    share_t [WIDTH-1:0] x_q;
    share_t [WIDTH-1:0] y_q;
    logic [WIDTH-1:0]   rnd_q;

    assign clr  = rst | zeroize;
    assign r0   = rnd_i[RND_R0*WIDTH +: WIDTH];
    assign r1   = rnd_i[RND_R1*WIDTH +: WIDTH];
    assign radd = rnd_i[RND_ADD*WIDTH +: WIDTH];

    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign in_ready_o  = credit_used < (CW+1)'(DEPTH);
    assign acc         = in_valid_i & rnd_valid_i & in_ready_o;
    assign wr_en       = vld_q[ADD_LAT];
    assign rd_en       = out_valid_o & out_ready_i;

    assign add_x_o   = x_q;
    assign add_y_o   = y_q;
    assign add_rnd_o = rnd_q;

    // Re-mask each arithmetic share separately; idle cycles present zeros.
    always_ff @(posedge clk) begin
        if (clr || !acc) begin
            x_q   <= '0;
            y_q   <= '0;
            rnd_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                x_q[i] <= {r0[i], a0_i[i] ^ r0[i]};
                y_q[i] <= {r1[i], a1_i[i] ^ r1[i]};
            end
            rnd_q <= radd;
        end
    end

    // Valid pipeline tracking the adder's fixed latency.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[ADD_LAT-1:0], acc};
        end
    end

    // In-flight count: up on accept, down when the result lands in the FIFO.
    always_ff @(posedge clk) begin
        if (clr) begin
            inflight_q <= '0;
        end else begin
            unique case ({acc, wr_en})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    abr_masked_share_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_data (add_s_i),
        .rd_en   (rd_en),
        .rd_data (out_s_o),
        .valid   (out_valid_o),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_abr_masked_a2b_ctrl.sv
// Scoreboard bench for abr_masked_a2b_ctrl with a behavioural adder model.
// Expected results are (a0+a1) mod 2^W queued at accept time.
module tb_abr_masked_a2b_ctrl;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int LAT = W + 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               zeroize;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [W-1:0]       a0_i;
    logic [W-1:0]       a1_i;
    logic               rnd_valid_i;
    logic [3*W-1:0]     rnd_i;
    logic [W-1:0][1:0]  add_x_o;
    logic [W-1:0][1:0]  add_y_o;
    logic [W-1:0]       add_rnd_o;
    logic [W-1:0][1:0]  add_s_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [W-1:0][1:0]  out_s_o;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    abr_masked_a2b_ctrl #(.WIDTH(W), .DEPTH(D), .ADD_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .zeroize     (zeroize),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a0_i        (a0_i),
        .a1_i        (a1_i),
        .rnd_valid_i (rnd_valid_i),
        .rnd_i       (rnd_i),
        .add_x_o     (add_x_o),
        .add_y_o     (add_y_o),
        .add_rnd_o   (add_rnd_o),
        .add_s_i     (add_s_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_s_o     (out_s_o)
    );

    function automatic logic [W-1:0] rec(input logic [W-1:0][1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[i][0] ^ v[i][1];
        return r;
    endfunction

    function automatic logic [W-1:0][1:0] share(input logic [W-1:0] v,
                                                input logic [W-1:0] m);
        logic [W-1:0][1:0] s;
        for (int i = 0; i < W; i++) s[i] = {m[i], v[i] ^ m[i]};
        return s;
    endfunction

    // Behavioural adder: sum of recombined operands, freshly shared, LAT cycles later.
    logic [W-1:0][1:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= share(rec(add_x_o) + rec(add_y_o), W'($urandom));
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign add_s_i = apipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every output handshake; flag any output with nothing pending.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stale_output: got %0h required no output",
                             rec(out_s_o));
                end else if (out_ready_i) begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(rec(out_s_o)), 32'(e));
                end
            end
        end
    end

    task automatic step(input logic iv, input logic rv,
                        input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [3*W-1:0] rnd, input logic ordy,
                        input logic zz, output logic acc);
        logic [W-1:0] s;
        @(negedge clk);
        in_valid_i  = iv;
        rnd_valid_i = rv;
        a0_i        = a0;
        a1_i        = a1;
        rnd_i       = rnd;
        out_ready_i = ordy;
        zeroize     = zz;
        #1;
        if (!rst) chk("in_ready", 32'(in_ready_o), 32'(exp_q.size() < D));
        acc = iv & rv & in_ready_o;
        if (acc) begin
            s = a0 + a1;
            exp_q.push_back(s);
        end
        if (zz) begin
            @(posedge clk);
            #1;
            exp_q.delete();
        end
    endtask

    task automatic idle(input logic ordy);
        logic a;
        step(1'b0, 1'b1, '0, '0, '0, ordy, 1'b0, a);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        logic [W-1:0] r0, r1, ra, a0, a1;
        int n, cnt;

        rst = 1'b1; zeroize = 1'b0; in_valid_i = 1'b0; rnd_valid_i = 1'b0;
        a0_i = '0; a1_i = '0; rnd_i = '0; out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out_s", 32'(out_s_o), 32'd0);
        chk("rst_add_x", 32'(add_x_o), 32'd0);
        chk("rst_add_y", 32'(add_y_o), 32'd0);
        chk("rst_add_rnd", 32'(add_rnd_o), 32'd0);
        rst = 1'b0;

        // Single conversion with known masks and latency measurement.
        r0 = 8'h5A; r1 = 8'hC3; ra = W'($urandom);
        step(1'b1, 1'b1, 8'hF0, 8'h25, {ra, r1, r0}, 1'b1, 1'b0, acc);
        chk("single_accept", 32'(acc), 32'd1);
        n = 0;
        do begin
            idle(1'b1);
            n++;
            if (n == 1) begin
                chk("single_x_rec", 32'(rec(add_x_o)), 32'hF0);
                chk("single_y_rec", 32'(rec(add_y_o)), 32'h25);
                chk("single_x_shares", 32'(add_x_o), 32'(share(8'hF0, r0)));
                chk("single_y_shares", 32'(add_y_o), 32'(share(8'h25, r1)));
                chk("single_add_rnd", 32'(add_rnd_o), 32'(ra));
            end
            if (n == 2) begin
                chk("idle_x_zero", 32'(add_x_o), 32'd0);
                chk("idle_rnd_zero", 32'(add_rnd_o), 32'd0);
            end
        end while (!out_valid_o && n < 40);
        chk("single_latency", 32'(n), 32'(LAT + 2));
        drain();

        // Random stream with an always-ready consumer.
        cnt = 0; n = 0;
        while (cnt < 32 && n < 2000) begin
            step(1'b1, 1'b1, W'($urandom), W'($urandom), 24'($urandom),
                 1'b1, 1'b0, acc);
            if (acc) cnt++;
            n++;
        end
        chk("stream_accepts", 32'(cnt), 32'd32);
        drain();

        // Stalled consumer: credits run out at DEPTH, one read frees one slot.
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, W'($urandom), W'($urandom), 24'($urandom),
                 1'b0, 1'b0, acc);
            if (acc) cnt++;
        end
        chk("stall_accepts", 32'(cnt), 32'(D));
        chk("stall_in_ready", 32'(in_ready_o), 32'd0);
        idle(1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, W'($urandom), W'($urandom), 24'($urandom),
                 1'b0, 1'b0, acc);
            if (acc) cnt++;
        end
        chk("release_accepts", 32'(cnt), 32'd1);
        drain();

        // No randomness: nothing accepted and adder operands stay zero.
        step(1'b1, 1'b0, 8'h3C, 8'h77, 24'($urandom), 1'b1, 1'b0, acc);
        chk("norand_accept", 32'(acc), 32'd0);
        step(1'b1, 1'b0, 8'h3C, 8'h77, 24'($urandom), 1'b1, 1'b0, acc);
        chk("norand_x_zero", 32'(add_x_o), 32'd0);
        chk("norand_y_zero", 32'(add_y_o), 32'd0);

        // Zeroize with two results buffered and two still in the adder.
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b1, W'($urandom), W'($urandom), 24'($urandom),
                 1'b0, 1'b0, acc);
        repeat (LAT + 3) idle(1'b0);
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b1, W'($urandom), W'($urandom), 24'($urandom),
                 1'b0, 1'b0, acc);
        idle(1'b0);
        chk("pre_zeroize_valid", 32'(out_valid_o), 32'd1);
        step(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b1, acc);
        idle(1'b0);
        chk("zeroize_out_valid", 32'(out_valid_o), 32'd0);
        chk("zeroize_in_ready", 32'(in_ready_o), 32'd1);
        repeat (LAT + 4) idle(1'b1);
        chk("zeroize_no_late", 32'(out_valid_o), 32'd0);

        // Carry wrap: 0xFF + 0x01 recombines to 0x00.
        step(1'b1, 1'b1, 8'hFF, 8'h01, 24'($urandom), 1'b1, 1'b0, acc);
        chk("wrap_accept", 32'(acc), 32'd1);
        drain();

        // A few more random pairs with a randomly stalling consumer.
        for (int i = 0; i < 60; i++) begin
            a0 = W'($urandom); a1 = W'($urandom);
            step(1'($urandom), 1'b1, a0, a1, 24'($urandom),
                 1'($urandom), 1'b0, acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
